// File: rtl/qam16_pkg.sv
// Shared definitions for the 16QAM decision-threshold path: sample width,
// scheduler state encoding and the 2/3 gate scaling.
package qam16_pkg;

    localparam int unsigned DW = 26;

    // 1/2 + 1/8 + 1/32 approximates 2/3 of the tracked peak
    localparam int unsigned SH_A = 1;
    localparam int unsigned SH_B = 3;
    localparam int unsigned SH_C = 5;

    typedef enum logic [2:0] {
        IDLE,
        MEAS_I,
        UPD_I,
        MEAS_Q,
        UPD_Q
    } state_t;

    function automatic logic signed [DW-1:0] scale23(input logic signed [DW-1:0] p);
        return (p >>> SH_A) + (p >>> SH_B) + (p >>> SH_C);
    endfunction

endpackage

// File: rtl/mgate_sched_peak_track.sv
// Signed max/min peak tracker; both peaks restart from zero on clear, so max stays
// non-negative and min stays non-positive.
module peak_track #(
    parameter int unsigned DW = 26
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr,
    input  logic                 smp,
    input  logic signed [DW-1:0] din,
    output logic signed [DW-1:0] pk_max,
    output logic signed [DW-1:0] pk_min
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pk_max <= '0;
            pk_min <= '0;
        end else if (clr) begin
            pk_max <= '0;
            pk_min <= '0;
        end else if (smp) begin
            if (din > pk_max) pk_max <= din;
            if (din < pk_min) pk_min <= din;
        end
    end

endmodule

// File: rtl/mgate_sched.sv
// Time-shares one peak tracker between the I and Q branches and turns each window's
// peaks into upper/lower slicer gates, a half-span threshold and a lock flag.
module mgate_sched
    import qam16_pkg::*;
#(
    parameter int unsigned WIN_LOG2 = 8,
    parameter int unsigned LOCK_CNT = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic signed [DW-1:0] din_i,
    input  logic signed [DW-1:0] din_q,
    input  logic                 din_vld,
    output logic signed [DW-1:0] gate_up_i,
    output logic signed [DW-1:0] gate_dn_i,
    output logic signed [DW-1:0] gate_up_q,
    output logic signed [DW-1:0] gate_dn_q,
    output logic signed [DW-1:0] thr_i,
    output logic signed [DW-1:0] thr_q,
    output logic                 gate_vld,
    output logic                 gate_ch,
    output logic                 locked
);

    localparam logic [WIN_LOG2:0] WIN_LEN = {1'b1, {WIN_LOG2{1'b0}}};
    localparam logic [WIN_LOG2:0] CNT_ONE = {{WIN_LOG2{1'b0}}, 1'b1};
    localparam logic [3:0]        LOCK_V  = 4'(LOCK_CNT);

    state_t               state_q;
    logic [WIN_LOG2:0]    cnt_q;
    logic [WIN_LOG2:0]    cnt_inc;
    logic [3:0]           round_q;

    logic                 trk_clr;
    logic                 trk_smp;
    logic signed [DW-1:0] trk_din;
    logic signed [DW-1:0] pk_max;
    logic signed [DW-1:0] pk_min;

    logic signed [DW-1:0] new_up;
    logic signed [DW-1:0] new_dn;
    logic        [DW:0]   span;
    logic signed [DW-1:0] new_thr;

    always_comb begin
        trk_clr = 1'b0;
        trk_smp = 1'b0;
        trk_din = din_i;
        cnt_inc = cnt_q + CNT_ONE;
        if (!en || state_q == UPD_I || state_q == UPD_Q) trk_clr = 1'b1;
        if (en && din_vld && (state_q == MEAS_I || state_q == MEAS_Q)) trk_smp = 1'b1;
        if (state_q == MEAS_Q) trk_din = din_q;
    end

    // Span is formed one bit wider so full-scale peaks of opposite sign cannot wrap
    always_comb begin
        new_up  = scale23(pk_max);
        new_dn  = scale23(pk_min);
        span    = {new_up[DW-1], new_up} - {new_dn[DW-1], new_dn};
        new_thr = span[DW:1];
    end

    peak_track #(
        .DW(DW)
    ) u_peak_track (
        .clk   (clk),
        .rst   (rst),
        .clr   (trk_clr),
        .smp   (trk_smp),
        .din   (trk_din),
        .pk_max(pk_max),
        .pk_min(pk_min)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            round_q   <= '0;
            gate_up_i <= '0;
            gate_dn_i <= '0;
            gate_up_q <= '0;
            gate_dn_q <= '0;
            thr_i     <= '0;
            thr_q     <= '0;
            gate_vld  <= 1'b0;
            gate_ch   <= 1'b0;
            locked    <= 1'b0;
        end else begin
            gate_vld <= 1'b0;
            if (!en) begin
                state_q <= IDLE;
                cnt_q   <= '0;
                round_q <= '0;
                locked  <= 1'b0;
            end else begin
                unique case (state_q)
                    IDLE: state_q <= MEAS_I;
                    MEAS_I, MEAS_Q: begin
                        if (din_vld) begin
                            cnt_q <= cnt_inc;
                            if (cnt_inc == WIN_LEN) begin
                                state_q <= (state_q == MEAS_I) ? UPD_I : UPD_Q;
                            end
                        end
                    end
                    UPD_I: begin
                        gate_up_i <= new_up;
                        gate_dn_i <= new_dn;
                        thr_i     <= new_thr;
                        gate_vld  <= 1'b1;
                        gate_ch   <= 1'b0;
                        cnt_q     <= '0;
                        state_q   <= MEAS_Q;
                    end
                    UPD_Q: begin
                        gate_up_q <= new_up;
                        gate_dn_q <= new_dn;
                        thr_q     <= new_thr;
                        gate_vld  <= 1'b1;
                        gate_ch   <= 1'b1;
                        cnt_q     <= '0;
                        state_q   <= MEAS_I;
                        if (round_q != LOCK_V) round_q <= round_q + 4'd1;
                        if (round_q + 4'd1 >= LOCK_V) locked <= 1'b1;
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mgate_sched.sv
// Directed bench for mgate_sched with 16-sample windows and a 4-round lock.
`timescale 1ns/1ps
module tb_mgate_sched;
    import qam16_pkg::*;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 en;
    logic                 din_vld;
    logic signed [DW-1:0] din_i;
    logic signed [DW-1:0] din_q;
    logic signed [DW-1:0] gate_up_i, gate_dn_i, gate_up_q, gate_dn_q, thr_i, thr_q;
    logic                 gate_vld, gate_ch, locked;

    logic signed [DW-1:0] pos_i, neg_i;
    logic                 phase;
    int                   n_chk  = 0;
    int                   n_fail = 0;

    always #5 clk = ~clk;

    mgate_sched #(
        .WIN_LOG2(4),
        .LOCK_CNT(4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .din_i    (din_i),
        .din_q    (din_q),
        .din_vld  (din_vld),
        .gate_up_i(gate_up_i),
        .gate_dn_i(gate_dn_i),
        .gate_up_q(gate_up_q),
        .gate_dn_q(gate_dn_q),
        .thr_i    (thr_i),
        .thr_q    (thr_q),
        .gate_vld (gate_vld),
        .gate_ch  (gate_ch),
        .locked   (locked)
    );

    // One clock; din_i alternates between pos_i and neg_i on every edge
    task automatic tick();
        @(posedge clk);
        #1;
        phase = ~phase;
        din_i = phase ? pos_i : neg_i;
    endtask

    task automatic wait_vld(output int cycles);
        cycles = 0;
        do begin
            tick();
            cycles++;
        end while (!gate_vld && cycles < 200);
        if (!gate_vld) begin
            n_chk++;
            n_fail++;
            $display("FAIL wait_vld: gate_vld not seen within %0d cycles", cycles);
        end
    endtask

    task automatic test_reset();
        logic any_vld;
        rst = 1'b0; en = 1'b0; din_vld = 1'b0; phase = 1'b0;
        pos_i = 26'sd3000; neg_i = -26'sd3000; din_i = '0; din_q = 26'sd500;
        #12;
        n_chk++; if (gate_up_i !== 26'sd0) begin n_fail++; $display("FAIL rst_up_i: got %0d want 0", gate_up_i); end
        n_chk++; if (thr_q !== 26'sd0) begin n_fail++; $display("FAIL rst_thr_q: got %0d want 0", thr_q); end
        n_chk++; if ({gate_vld, gate_ch, locked} !== 3'b000) begin
            n_fail++; $display("FAIL rst_flags: got %b want 000", {gate_vld, gate_ch, locked});
        end
        rst = 1'b1;
        din_vld = 1'b1;
        any_vld = 1'b0;
        repeat (5) begin
            tick();
            any_vld |= gate_vld;
        end
        n_chk++; if (any_vld !== 1'b0) begin n_fail++; $display("FAIL idle_hold: got vld=1 want 0"); end
    endtask

    task automatic test_i_window();
        int c;
        en = 1'b1;
        wait_vld(c);
        n_chk++; if (c != 18) begin n_fail++; $display("FAIL i_latency: got %0d want 18", c); end
        n_chk++; if (gate_ch !== 1'b0) begin n_fail++; $display("FAIL i_ch: got %b want 0", gate_ch); end
        n_chk++; if (gate_up_i !== 26'sd1968) begin n_fail++; $display("FAIL i_up: got %0d want 1968", gate_up_i); end
        n_chk++; if (gate_dn_i !== -26'sd1969) begin n_fail++; $display("FAIL i_dn: got %0d want -1969", gate_dn_i); end
        n_chk++; if (thr_i !== 26'sd1968) begin n_fail++; $display("FAIL i_thr: got %0d want 1968", thr_i); end
        n_chk++; if ({gate_up_q, gate_dn_q, thr_q} !== '0) begin
            n_fail++; $display("FAIL i_q_idle: got up=%0d dn=%0d thr=%0d want 0", gate_up_q, gate_dn_q, thr_q);
        end
        tick();
        n_chk++; if (gate_vld !== 1'b0) begin n_fail++; $display("FAIL vld_pulse: got %b want 0", gate_vld); end
    endtask

    task automatic test_q_window();
        int c;
        wait_vld(c);
        n_chk++; if (gate_ch !== 1'b1) begin n_fail++; $display("FAIL q_ch: got %b want 1", gate_ch); end
        n_chk++; if (gate_up_q !== 26'sd327) begin n_fail++; $display("FAIL q_up: got %0d want 327", gate_up_q); end
        n_chk++; if (gate_dn_q !== 26'sd0) begin n_fail++; $display("FAIL q_dn: got %0d want 0", gate_dn_q); end
        n_chk++; if (thr_q !== 26'sd163) begin n_fail++; $display("FAIL q_thr: got %0d want 163", thr_q); end
        n_chk++; if (gate_up_i !== 26'sd1968 || thr_i !== 26'sd1968) begin
            n_fail++; $display("FAIL q_i_hold: got up=%0d thr=%0d want 1968", gate_up_i, thr_i);
        end
    endtask

    task automatic test_back_to_back();
        int c;
        repeat (16) tick();
        din_q = 26'sd20000;
        tick();
        n_chk++; if (gate_vld !== 1'b1 || gate_ch !== 1'b0) begin
            n_fail++; $display("FAIL b2b_i_pulse: got vld=%b ch=%b want 1 0", gate_vld, gate_ch);
        end
        din_q = 26'sd500;
        tick();
        tick();
        din_vld = 1'b0;
        din_q = -26'sd7000;
        repeat (3) tick();
        din_vld = 1'b1;
        din_q = 26'sd500;
        wait_vld(c);
        n_chk++; if (c != 15) begin n_fail++; $display("FAIL gap_latency: got %0d want 15", c); end
        n_chk++; if (gate_up_q !== 26'sd327) begin n_fail++; $display("FAIL marker_up_q: got %0d want 327", gate_up_q); end
        n_chk++; if (gate_dn_q !== 26'sd0) begin n_fail++; $display("FAIL gap_dn_q: got %0d want 0", gate_dn_q); end
        n_chk++; if (locked !== 1'b0) begin n_fail++; $display("FAIL lock_early: got %b want 0", locked); end
    endtask

    task automatic test_lock();
        int c;
        wait_vld(c);
        wait_vld(c);
        n_chk++; if (locked !== 1'b0) begin n_fail++; $display("FAIL lock_r3: got %b want 0", locked); end
        wait_vld(c);
        wait_vld(c);
        n_chk++; if (locked !== 1'b1 || gate_ch !== 1'b1) begin
            n_fail++; $display("FAIL lock_r4: got locked=%b ch=%b want 1 1", locked, gate_ch);
        end
        en = 1'b0;
        tick();
        en = 1'b1;
        n_chk++; if (locked !== 1'b0) begin n_fail++; $display("FAIL en_unlock: got %b want 0", locked); end
        n_chk++; if (gate_up_i !== 26'sd1968 || gate_up_q !== 26'sd327) begin
            n_fail++; $display("FAIL en_hold: got up_i=%0d up_q=%0d want 1968 327", gate_up_i, gate_up_q);
        end
        wait_vld(c);
        n_chk++; if (c != 18 || gate_ch !== 1'b0) begin
            n_fail++; $display("FAIL en_restart: got c=%0d ch=%b want 18 0", c, gate_ch);
        end
        for (int r = 1; r <= 4; r++) begin
            wait_vld(c);
            n_chk++; if (locked !== (r == 4)) begin
                n_fail++; $display("FAIL relock_r%0d: got %b want %b", r, locked, r == 4);
            end
            if (r < 4) wait_vld(c);
        end
    endtask

    task automatic test_async_reset_full_scale();
        int c;
        wait_vld(c);
        repeat (5) tick();
        #2;
        rst = 1'b0;
        #1;
        n_chk++; if ({gate_up_i, gate_dn_i, thr_i} !== '0) begin
            n_fail++; $display("FAIL arst_i: got up=%0d dn=%0d thr=%0d want 0", gate_up_i, gate_dn_i, thr_i);
        end
        n_chk++; if ({gate_up_q, thr_q} !== '0 || locked !== 1'b0) begin
            n_fail++; $display("FAIL arst_q: got up=%0d thr=%0d locked=%b want 0", gate_up_q, thr_q, locked);
        end
        pos_i = {1'b0, {(DW-1){1'b1}}};
        neg_i = {1'b1, {(DW-1){1'b0}}};
        rst = 1'b1;
        wait_vld(c);
        n_chk++; if (c != 18 || gate_ch !== 1'b0) begin
            n_fail++; $display("FAIL arst_restart: got c=%0d ch=%b want 18 0", c, gate_ch);
        end
        n_chk++; if (gate_up_i !== 26'sd22020093) begin n_fail++; $display("FAIL fs_up: got %0d want 22020093", gate_up_i); end
        n_chk++; if (gate_dn_i !== -26'sd22020096) begin n_fail++; $display("FAIL fs_dn: got %0d want -22020096", gate_dn_i); end
        n_chk++; if (thr_i !== 26'sd22020094) begin n_fail++; $display("FAIL fs_thr: got %0d want 22020094", thr_i); end
    endtask

    initial begin
        test_reset();
        test_i_window();
        test_q_window();
        test_back_to_back();
        test_lock();
        test_async_reset_full_scale();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
